// File: rtl/seq_divider.sv
// Iterative 32-bit restoring divider for MIPS DIV/DIVU: one quotient bit per cycle,
// operands captured at start, signs fixed up once at the end.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        validIn,
    input  logic        sign,
    input  logic [31:0] SrcA,
    input  logic [31:0] SrcB,
    output logic        validOut,
    output logic        busy,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX,
        S_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    rem_q, rem_d;
    logic [31:0]    quo_q, quo_d;
    logic [31:0]    div_q, div_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           negq_q, negq_d;
    logic           negr_q, negr_d;
    logic           dz_q, dz_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;

    logic [31:0]    abs_a, abs_b;
    logic [32:0]    shifted, trial;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            div_q   <= '0;
            cnt_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            dz_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            dz_q    <= dz_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        dz_d    = dz_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        abs_a   = (sign && SrcA[31]) ? (~SrcA + 32'd1) : SrcA;
        abs_b   = (sign && SrcB[31]) ? (~SrcB + 32'd1) : SrcB;
        // The partial remainder never exceeds 32 bits, so the 33-bit trial's MSB is its sign.
        shifted = {rem_q, quo_q[31]};
        trial   = shifted - {1'b0, div_q};

        case (state_q)
            S_IDLE: begin
                if (validIn) begin
                    quo_d   = abs_a;
                    rem_d   = '0;
                    div_d   = abs_b;
                    negq_d  = sign & (SrcA[31] ^ SrcB[31]);
                    negr_d  = sign & SrcA[31];
                    dz_d    = (SrcB == 32'd0);
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (!trial[32]) begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = shifted[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                // With a zero divisor every trial succeeds, so the remainder ends up as |SrcA|
                // and the negR fixup restores the original dividend bits for Hi.
                lo_d    = dz_q ? 32'hFFFF_FFFF : (negq_q ? (~quo_q + 32'd1) : quo_q);
                hi_d    = negr_q ? (~rem_q + 32'd1) : rem_q;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign validOut = (state_q == S_DONE);
    assign busy     = (state_q == S_RUN) || (state_q == S_FIX);
    assign Hi       = hi_q;
    assign Lo       = lo_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed-vector bench for seq_divider: latency, results, reset abort and input isolation.
module tb_seq_divider;
    logic        clk;
    logic        reset;
    logic        validIn;
    logic        sign;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        validOut;
    logic        busy;
    logic [31:0] Hi;
    logic [31:0] Lo;

    int n_vec = 0;
    int n_err = 0;

    seq_divider #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .validIn  (validIn),
        .sign     (sign),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .validOut (validOut),
        .busy     (busy),
        .Hi       (Hi),
        .Lo       (Lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%08h", tag, got);
        end
    endtask

    // Start one divide, optionally scramble inputs during the run, then check latency and results.
    task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input bit scramble);
        int lat;
        @(negedge clk);
        validIn = 1'b1;
        sign    = sg;
        SrcA    = a;
        SrcB    = b;
        @(posedge clk);
        #1;
        validIn = 1'b0;
        lat     = 0;
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
        while (!validOut && lat < 40) begin
            if (scramble) begin
                SrcA    = $urandom;
                SrcB    = $urandom;
                sign    = 1'($urandom_range(0, 1));
                validIn = (lat % 2) == 1;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        validIn = 1'b0;
        chk({tag, "_lat"}, 32'(lat), 32'd33);
        chk({tag, "_lo"}, Lo, exp_lo);
        chk({tag, "_hi"}, Hi, exp_hi);
        chk({tag, "_busy_done"}, {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_pulse"}, {31'b0, validOut}, 32'd0);
    endtask

    initial begin
        int lat;
        bit seen;

        reset   = 1'b1;
        validIn = 1'b0;
        sign    = 1'b0;
        SrcA    = '0;
        SrcB    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", Hi, 32'd0);
        chk("rst_lo", Lo, 32'd0);
        chk("rst_valid", {31'b0, validOut}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        run_div("divu_100_7",    1'b0, 32'd100,       32'd7,         32'd14,        32'd2,         1'b0);
        run_div("div_m7_2",      1'b1, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_div("div_7_m2",      1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,         1'b0);
        run_div("divu_max_1",    1'b0, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 32'd0,         1'b0);
        run_div("divu_max_max",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0);
        run_div("divu_5_max",    1'b0, 32'd5,         32'hFFFF_FFFF, 32'd0,         32'd5,         1'b0);
        run_div("div_ovf",       1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,         1'b0);
        run_div("div_by_zero",   1'b1, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b0);
        run_div("div_neg_by_0",  1'b1, 32'h8000_0001, 32'd0,         32'hFFFF_FFFF, 32'h8000_0001, 1'b0);

        // Reset in the middle of a run: nothing completes and results clear.
        @(negedge clk);
        validIn = 1'b1;
        sign    = 1'b0;
        SrcA    = 32'd1000;
        SrcB    = 32'd3;
        @(posedge clk);
        #1;
        validIn = 1'b0;
        repeat (14) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_hi", Hi, 32'd0);
        chk("midrst_lo", Lo, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_valid", {31'b0, validOut}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        seen  = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (validOut) seen = 1'b1;
        end
        chk("midrst_no_valid", {31'b0, seen}, 32'd0);
        run_div("rst_restart",   1'b0, 32'd1000,      32'd3,         32'd333,       32'd1,         1'b0);

        run_div("isolate_50_5",  1'b0, 32'd50,        32'd5,         32'd10,        32'd0,         1'b1);

        // validIn held through DONE: the following IDLE cycle starts with the operands present then.
        @(negedge clk);
        validIn = 1'b1;
        sign    = 1'b0;
        SrcA    = 32'd84;
        SrcB    = 32'd4;
        @(posedge clk);
        #1;
        sign = 1'b1;
        SrcA = 32'hFFFF_FF9C;
        SrcB = 32'd7;
        lat  = 0;
        while (!validOut && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold_first_lat", 32'(lat), 32'd33);
        chk("hold_first_lo", Lo, 32'd21);
        chk("hold_first_hi", Hi, 32'd0);
        @(posedge clk);
        #1;
        chk("hold_done_exit_busy", {31'b0, busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("hold_restart_busy", {31'b0, busy}, 32'd1);
        validIn = 1'b0;
        lat     = 35;
        while (!validOut && lat < 80) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold_second_lat", 32'(lat), 32'd68);
        chk("hold_second_lo", Lo, 32'hFFFF_FFF2);
        chk("hold_second_hi", Hi, 32'hFFFF_FFFE);

        repeat (2) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
